// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: operation encoding
// and default address width.
package pc_pkg;

    localparam int PC_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        PC_OP_HOLD,
        PC_OP_INC,
        PC_OP_BRANCH,
        PC_OP_JUMP,
        PC_OP_CALL,
        PC_OP_RET
    } pc_op_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular LIFO of return addresses. A push while full overwrites the oldest
// entry; a pop while empty leaves the stack untouched and reports underflow.
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH  = PC_ADDR_WIDTH,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        pushData,
    output logic [ADDR_WIDTH-1:0]        topData,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflowEvt,
    output logic                         underflowEvt
);

    localparam int PTR_WIDTH = $clog2(STACK_DEPTH);
    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] entries [STACK_DEPTH];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  topPtr;
    logic [PTR_WIDTH:0]    count;

    // wrPtr is the next free slot; when full it also points at the oldest entry
    assign topPtr       = wrPtr - PTR_WIDTH'(1);
    assign topData      = entries[topPtr];
    assign depth        = count;
    assign empty        = (count == '0);
    assign full         = (count == FULL_COUNT);
    assign overflowEvt  = push && !pop && full;
    assign underflowEvt = pop && empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            count <= '0;
        end else if (pop) begin
            if (!empty) begin
                wrPtr <= topPtr;
                count <= count - (PTR_WIDTH + 1)'(1);
            end
        end else if (push) begin
            wrPtr <= wrPtr + PTR_WIDTH'(1);
            if (!full) begin
                count <= count + (PTR_WIDTH + 1)'(1);
            end
        end
    end

    // Entry contents need no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push && !pop) begin
            entries[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with branch, jump and call/return via a circular
// return-address stack. Optional target alignment check: PC_ALIGN_CHECK_EN.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = PC_ADDR_WIDTH,
    parameter int                    STEP        = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter int                    STACK_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pcWrite,
    input  logic                         jump,
    input  logic                         branchTaken,
    input  logic [ADDR_WIDTH-1:0]        branchOffset,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         clearFlags,
    input  logic [ADDR_WIDTH-1:0]        inputAddress,
    output logic [ADDR_WIDTH-1:0]        outputAddress,
    output logic [$clog2(STACK_DEPTH):0] stackDepth,
    output logic                         stackEmpty,
    output logic                         stackFull,
    output logic                         stackOverflow,
    output logic                         stackUnderflow,
    output logic                         misalignFault
);

    pc_op_t                op;
    logic [ADDR_WIDTH-1:0] pcReg;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic [ADDR_WIDTH-1:0] seqAddr;
    logic [ADDR_WIDTH-1:0] branchAddr;
    logic [ADDR_WIDTH-1:0] rawTarget;
    logic [ADDR_WIDTH-1:0] loadTarget;
    logic [ADDR_WIDTH-1:0] returnAddr;
    logic [ADDR_WIDTH-1:0] topData;
    logic                  push;
    logic                  pop;
    logic                  overflowEvt;
    logic                  underflowEvt;
    logic                  misalignEvt;
    logic                  overflowFlag;
    logic                  underflowFlag;
    logic                  misalignFlag;

    always_comb begin
        op = PC_OP_HOLD;
        if (pcWrite) begin
            if (ret)              op = PC_OP_RET;
            else if (call)        op = PC_OP_CALL;
            else if (jump)        op = PC_OP_JUMP;
            else if (branchTaken) op = PC_OP_BRANCH;
            else                  op = PC_OP_INC;
        end
    end

    assign seqAddr    = pcReg + ADDR_WIDTH'(STEP);
    assign branchAddr = pcReg + branchOffset;
    assign rawTarget  = (op == PC_OP_BRANCH) ? branchAddr : inputAddress;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STEP - 1);

    assign loadTarget  = rawTarget & ~LOW_MASK;
    assign returnAddr  = seqAddr & ~LOW_MASK;
    assign misalignEvt = ((op == PC_OP_JUMP) || (op == PC_OP_CALL) || (op == PC_OP_BRANCH))
                         && ((rawTarget & LOW_MASK) != '0);
`else
    assign loadTarget  = rawTarget;
    assign returnAddr  = seqAddr;
    assign misalignEvt = 1'b0;
`endif

    always_comb begin
        pcNext = pcReg;
        case (op)
            PC_OP_INC:    pcNext = seqAddr;
            PC_OP_BRANCH,
            PC_OP_JUMP,
            PC_OP_CALL:   pcNext = loadTarget;
            // An empty-stack return falls through to the next instruction
            PC_OP_RET:    pcNext = stackEmpty ? seqAddr : topData;
            default:      pcNext = pcReg;
        endcase
    end

    assign push = (op == PC_OP_CALL);
    assign pop  = (op == PC_OP_RET);

    return_addr_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock        (clock),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop),
        .pushData     (returnAddr),
        .topData      (topData),
        .depth        (stackDepth),
        .empty        (stackEmpty),
        .full         (stackFull),
        .overflowEvt  (overflowEvt),
        .underflowEvt (underflowEvt)
    );

    // Sticky flags: a new event outranks a clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcReg         <= RESET_ADDR;
            overflowFlag  <= 1'b0;
            underflowFlag <= 1'b0;
            misalignFlag  <= 1'b0;
        end else begin
            pcReg         <= pcNext;
            overflowFlag  <= overflowEvt  | (overflowFlag  & ~clearFlags);
            underflowFlag <= underflowEvt | (underflowFlag & ~clearFlags);
            misalignFlag  <= misalignEvt  | (misalignFlag  & ~clearFlags);
        end
    end

    assign outputAddress  = pcReg;
    assign stackOverflow  = overflowFlag;
    assign stackUnderflow = underflowFlag;
    assign misalignFault  = misalignFlag;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_program_counter_stack;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pcWrite = 1'b0;
    logic        jump = 1'b0;
    logic        branchTaken = 1'b0;
    logic [15:0] branchOffset = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        clearFlags = 1'b0;
    logic [15:0] inputAddress = '0;
    logic [15:0] outputAddress;
    logic [2:0]  stackDepth;
    logic        stackEmpty;
    logic        stackFull;
    logic        stackOverflow;
    logic        stackUnderflow;
    logic        misalignFault;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mPc = 16'h0000;
    logic [15:0] mStack[$];
    logic        mOvf = 1'b0;
    logic        mUnf = 1'b0;
    logic        mMis = 1'b0;

    program_counter_stack #(
        .ADDR_WIDTH  (16),
        .STEP        (2),
        .RESET_ADDR  (16'h0000),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pcWrite        (pcWrite),
        .jump           (jump),
        .branchTaken    (branchTaken),
        .branchOffset   (branchOffset),
        .call           (call),
        .ret            (ret),
        .clearFlags     (clearFlags),
        .inputAddress   (inputAddress),
        .outputAddress  (outputAddress),
        .stackDepth     (stackDepth),
        .stackEmpty     (stackEmpty),
        .stackFull      (stackFull),
        .stackOverflow  (stackOverflow),
        .stackUnderflow (stackUnderflow),
        .misalignFault  (misalignFault)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mPc = 16'h0000;
        mStack.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        mMis = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic drive(input logic pw, input logic rt, input logic cl, input logic jp,
                         input logic br, input logic [15:0] off, input logic [15:0] addr,
                         input logic clr);
        logic        eO, eU, eM;
        logic [15:0] tgt;
        logic [15:0] raddr;
        pcWrite = pw; ret = rt; call = cl; jump = jp; branchTaken = br;
        branchOffset = off; inputAddress = addr; clearFlags = clr;
        eO = 1'b0; eU = 1'b0; eM = 1'b0;
        if (pw) begin
            if (rt) begin
                if (mStack.size() > 0) mPc = mStack.pop_back();
                else begin
                    mPc = mPc + 16'd2;
                    eU  = 1'b1;
                end
            end else if (cl || jp || br) begin
                tgt = (cl || jp) ? addr : mPc + off;
`ifdef PC_ALIGN_CHECK_EN
                eM     = tgt[0];
                tgt[0] = 1'b0;
`endif
                if (cl) begin
                    raddr = mPc + 16'd2;
`ifdef PC_ALIGN_CHECK_EN
                    raddr[0] = 1'b0;
`endif
                    mStack.push_back(raddr);
                    if (mStack.size() > DEPTH) begin
                        void'(mStack.pop_front());
                        eO = 1'b1;
                    end
                end
                mPc = tgt;
            end else begin
                mPc = mPc + 16'd2;
            end
        end
        mOvf = eO | (mOvf & ~clr);
        mUnf = eU | (mUnf & ~clr);
        mMis = eM | (mMis & ~clr);
        @(posedge clock);
        #1;
        pcWrite = 0; ret = 0; call = 0; jump = 0; branchTaken = 0; clearFlags = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (outputAddress !== 16'h0000) begin
            errors++; $display("FAIL reset_pc: got %h expected 0000", outputAddress);
        end
        checks++;
        if (stackDepth !== 3'd0 || stackEmpty !== 1'b1 || stackFull !== 1'b0) begin
            errors++; $display("FAIL reset_stack: depth %0d empty %b full %b expected 0 1 0",
                               stackDepth, stackEmpty, stackFull);
        end
        checks++;
        if ({stackOverflow, stackUnderflow, misalignFault} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000",
                               {stackOverflow, stackUnderflow, misalignFault});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
            checks++;
            if (outputAddress !== 16'(2 * i)) begin
                errors++; $display("FAIL increment_%0d: got %h expected %h", i, outputAddress, 16'(2 * i));
            end
        end
    endtask

    task automatic test_branch_wrap();
        drive(1, 0, 0, 1, 0, 16'h0, 16'h0010, 0);
        drive(1, 0, 0, 0, 1, 16'hFFF0, 16'h0, 0);
        checks++;
        if (outputAddress !== 16'h0000) begin
            errors++; $display("FAIL branch_back: got %h expected 0000", outputAddress);
        end
        drive(1, 0, 0, 1, 0, 16'h0, 16'hFFFE, 0);
        drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        checks++;
        if (outputAddress !== 16'h0000) begin
            errors++; $display("FAIL inc_wrap: got %h expected 0000", outputAddress);
        end
    endtask

    task automatic test_call_ret();
        logic [15:0] expPc [4] = '{16'h0100, 16'h0200, 16'h0102, 16'h0022};
        logic [2:0]  expDp [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        drive(1, 0, 0, 1, 0, 16'h0, 16'h0020, 0);
        drive(1, 0, 1, 0, 0, 16'h0, 16'h0100, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) drive(1, 0, 1, 0, 0, 16'h0, 16'h0200, 0);
            else if (i >= 2) drive(1, 1, 0, 0, 0, 16'h0, 16'h0, 0);
            checks++;
            if (outputAddress !== expPc[i] || stackDepth !== expDp[i]) begin
                errors++; $display("FAIL call_ret_%0d: pc %h depth %0d expected %h %0d",
                                   i, outputAddress, stackDepth, expPc[i], expDp[i]);
            end
        end
        // ret and call together: only the return happens
        drive(1, 0, 1, 0, 0, 16'h0, 16'h0300, 0);
        drive(1, 1, 1, 0, 0, 16'h0, 16'h0500, 0);
        checks++;
        if (outputAddress !== 16'h0024 || stackDepth !== 3'd0) begin
            errors++; $display("FAIL ret_over_call: pc %h depth %0d expected 0024 0", outputAddress, stackDepth);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] expRet [4] = '{16'h4002, 16'h3002, 16'h2002, 16'h1002};
        drive(1, 0, 0, 1, 0, 16'h0, 16'h0040, 1);
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 1, 0, 0, 16'h0, 16'(i * 16'h1000), 0);
            if (i == 4) begin
                checks++;
                if (stackFull !== 1'b1 || stackOverflow !== 1'b0) begin
                    errors++; $display("FAIL full_no_ovf: full %b ovf %b expected 1 0", stackFull, stackOverflow);
                end
            end
        end
        checks++;
        if (stackFull !== 1'b1 || stackOverflow !== 1'b1 || stackDepth !== 3'd4) begin
            errors++; $display("FAIL overflow: full %b ovf %b depth %0d expected 1 1 4",
                               stackFull, stackOverflow, stackDepth);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 16'h0, 16'h0, 0);
            checks++;
            if (outputAddress !== expRet[i] || stackDepth !== 3'(3 - i)) begin
                errors++; $display("FAIL pop_%0d: pc %h depth %0d expected %h %0d",
                                   i, outputAddress, stackDepth, expRet[i], 3 - i);
            end
        end
        drive(1, 1, 0, 0, 0, 16'h0, 16'h0, 0);
        checks++;
        if (outputAddress !== 16'h1004 || stackUnderflow !== 1'b1 || stackDepth !== 3'd0) begin
            errors++; $display("FAIL underflow: pc %h unf %b depth %0d expected 1004 1 0",
                               outputAddress, stackUnderflow, stackDepth);
        end
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
        checks++;
        if (stackOverflow !== 1'b0 || stackUnderflow !== 1'b0 || outputAddress !== 16'h1004) begin
            errors++; $display("FAIL clear_flags: ovf %b unf %b pc %h expected 0 0 1004",
                               stackOverflow, stackUnderflow, outputAddress);
        end
        // A set in the same cycle as a clear wins
        drive(1, 1, 0, 0, 0, 16'h0, 16'h0, 1);
        checks++;
        if (stackUnderflow !== 1'b1 || outputAddress !== 16'h1006) begin
            errors++; $display("FAIL set_beats_clear: unf %b pc %h expected 1 1006", stackUnderflow, outputAddress);
        end
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
    endtask

    task automatic test_stall_and_reset();
        drive(1, 0, 1, 0, 0, 16'h0, 16'h0600, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 1, 0, 16'h0, 16'h0700, 0);
            checks++;
            if (outputAddress !== 16'h0600 || stackDepth !== 3'd1) begin
                errors++; $display("FAIL stall_%0d: pc %h depth %0d expected 0600 1", i, outputAddress, stackDepth);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outputAddress !== 16'h0000 || stackDepth !== 3'd0) begin
            errors++; $display("FAIL async_reset: pc %h depth %0d expected 0000 0", outputAddress, stackDepth);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_align();
        drive(1, 0, 0, 1, 0, 16'h0, 16'h0103, 0);
        checks++;
`ifdef PC_ALIGN_CHECK_EN
        if (outputAddress !== 16'h0102 || misalignFault !== 1'b1) begin
            errors++; $display("FAIL align_jump: pc %h mis %b expected 0102 1", outputAddress, misalignFault);
        end
`else
        if (outputAddress !== 16'h0103 || misalignFault !== 1'b0) begin
            errors++; $display("FAIL align_jump: pc %h mis %b expected 0103 0", outputAddress, misalignFault);
        end
`endif
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 1);
        checks++;
        if (misalignFault !== 1'b0) begin
            errors++; $display("FAIL align_clear: mis %b expected 0", misalignFault);
        end
        drive(1, 0, 0, 1, 0, 16'h0, 16'h0100, 0);
    endtask

    task automatic test_random();
        logic        pw, rt, cl, jp, br, clr;
        logic [15:0] off, addr;
        for (int n = 0; n < 400; n++) begin
            pw   = ($urandom % 8) != 0;
            rt   = ($urandom % 5) == 0;
            cl   = ($urandom % 4) == 0;
            jp   = ($urandom % 6) == 0;
            br   = ($urandom % 4) == 0;
            clr  = ($urandom % 10) == 0;
            off  = 16'($urandom);
            addr = 16'($urandom);
            if (($urandom % 4) != 0) off[0] = 1'b0;
            if (($urandom % 4) != 0) addr[0] = 1'b0;
            drive(pw, rt, cl, jp, br, off, addr, clr);
            checks++;
            if (outputAddress !== mPc) begin
                errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", n, outputAddress, mPc);
            end
            checks++;
            if (stackDepth !== 3'(mStack.size()) || stackEmpty !== (mStack.size() == 0)
                || stackFull !== (mStack.size() == DEPTH)) begin
                errors++; $display("FAIL rand_stack[%0d]: depth %0d empty %b full %b expected depth %0d",
                                   n, stackDepth, stackEmpty, stackFull, mStack.size());
            end
            checks++;
            if ({stackOverflow, stackUnderflow, misalignFault} !== {mOvf, mUnf, mMis}) begin
                errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", n,
                                   {stackOverflow, stackUnderflow, misalignFault}, {mOvf, mUnf, mMis});
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_branch_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_stall_and_reset();
        test_align();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised next-generation program counter for the CPU fetch stage. Supports stall, sequential increment, PC-relative branch, absolute jump, and call/return through an internal circular return-address stack. Sits between the control unit, which drives the strobes, and the instruction memory address port, which consumes outputAddress.

Parameters:
ADDR_WIDTH, 16, width of every address and offset.
STEP, 2, sequential increment in address units; must be a power of two, at least 1.
RESET_ADDR, 16'h0000, PC value loaded on reset.
STACK_DEPTH, 4, number of return-address entries; power of two, at least 2.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
pcWrite  input  1  global update enable; 0 = stall, hold everything
jump  input  1  load inputAddress absolute
branchTaken  input  1  PC <= PC + branchOffset
branchOffset  input  ADDR_WIDTH  signed two's-complement offset
call  input  1  push PC+STEP, load inputAddress
ret  input  1  pop top of stack into PC
clearFlags  input  1  clear sticky overflow/underflow flags
inputAddress  input  ADDR_WIDTH  absolute target for jump/call
outputAddress  output  ADDR_WIDTH  current PC
stackDepth  output  clog2(STACK_DEPTH)+1  valid entries
stackEmpty  output  1  stackDepth == 0
stackFull  output  1  stackDepth == STACK_DEPTH
stackOverflow  output  1  sticky flag: push while full
stackUnderflow  output  1  sticky flag: pop while empty
misalignFault  output  1  sticky flag: see Optional Feature

Behaviour:
- Reset (asynchronous, active-low):
  - outputAddress = RESET_ADDR
  - stackDepth = 0; stack pointer = 0
  - all flags = 0
  - stack entry contents are don't-care
- All updates occur on the rising clock edge only; there are no combinational paths from inputs to outputAddress.
- Next-PC latency is 1 cycle: an operation sampled at edge N is visible on outputAddress after edge N.
- pcWrite = 0: PC, stack and depth all hold; strobes are ignored. clearFlags still acts regardless of pcWrite.
- pcWrite = 1: exactly one operation per cycle, chosen by fixed priority: ret > call > jump > branchTaken > increment (PC + STEP).
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH. Wrap-around is silent (e.g. 16'hFFFE + 2 = 16'h0000).
- call:
  - Pushes (PC + STEP) mod 2^ADDR_WIDTH, then PC <= inputAddress.
  - When full: overwrite the oldest entry (circular pointer wraps), depth stays STACK_DEPTH, set stackOverflow.
- ret:
  - When not empty: PC <= top entry, depth decrements.
  - When empty: PC <= PC + STEP, depth stays 0, set stackUnderflow.
- Simultaneous ret and call: only ret executes, per priority. The call is dropped and no push occurs.
- Sticky flags:
  - Cleared by clearFlags = 1.
  - A set and a clear in the same cycle resolve to set.
- Reset asserted mid-operation: immediate return to reset state. No partial push or pop is retained.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - Any jump or call target, and any branch result, whose low log2(STEP) bits are nonzero sets the sticky misalignFault flag.
  - The loaded PC has those low bits forced to 0.
  - A pushed return address is always aligned.
  - misalignFault is cleared by clearFlags.
- Undefined: targets are loaded unmodified; misalignFault is tied to 0.
- When STEP = 1 the check is vacuous and the flag stays 0.

Decomposition:
- Shared package pc_pkg holds:
  - pc_op_t enum (PC_OP_HOLD, PC_OP_INC, PC_OP_BRANCH, PC_OP_JUMP, PC_OP_CALL, PC_OP_RET)
  - the default-width constant PC_ADDR_WIDTH = 16
- The priority decoder lives in the top module and produces a pc_op_t.
- One natural sub-module, return_addr_stack: circular LIFO with push/pop, depth count, full/empty, and overflow-overwrite. It is parameterised by ADDR_WIDTH and STACK_DEPTH.

Test Plan:
- Reset then pcWrite=1 with no strobes for 3 cycles -> outputAddress 0000, 0002, 0004, 0006.
- At PC=0010, branchTaken with branchOffset=16'hFFF0 -> PC=0000 next cycle; PC=FFFE plus increment -> 0000 (wrap).
- call to 0100 at PC=0020, call to 0200, ret, ret -> PC sequence 0100, 0200, 0102, 0022; stackDepth sequence 1, 2, 1, 0.
- Five calls with STACK_DEPTH=4 -> stackFull=1, stackOverflow=1. Four rets then return the four newest addresses; a fifth ret gives PC+2 and stackUnderflow=1. clearFlags then clears both flags.
- pcWrite=0 for 2 cycles with call=1 and jump=1 -> PC and stackDepth unchanged. Assert reset_n=0 mid-cycle after a push -> outputAddress=0000 and stackDepth=0 immediately, without waiting for a clock edge.
- With PC_ALIGN_CHECK_EN defined: jump to 0103 -> PC=0102, misalignFault=1. Without the macro: PC=0103, misalignFault=0.
